// File: rtl/regfile_master_if.sv
// rtl/regfile_master_if.sv - Command, response and register-file signal bundle
interface regfile_master_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_dump;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_error;
  logic              rsp_last;
  logic [DATA_W-1:0] rf_din;
  logic [ADDR_W-1:0] rf_addr;
  logic              rf_wr;
  logic              rf_rd;
  logic [DATA_W-1:0] rf_dout;
  logic              rf_error;

  modport master (
    input  cmd_valid, cmd_write, cmd_dump, cmd_addr, cmd_wdata, rsp_ready, rf_dout, rf_error,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_addr, rsp_error, rsp_last,
           rf_din, rf_addr, rf_wr, rf_rd
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_dump, cmd_addr, cmd_wdata, rsp_ready, rf_dout, rf_error,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_addr, rsp_error, rsp_last,
           rf_din, rf_addr, rf_wr, rf_rd
  );
endinterface

// File: rtl/regfile_master.sv
// rtl/regfile_master.sv - Register-file access master: single read/write and full dump
module regfile_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic              clk,
  input logic              reset,
  regfile_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic              lat_write;
  logic              lat_dump;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              rsp_error_q;
  logic              rsp_last_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic              rf_wr_q;
  logic              rf_rd_q;
  logic [DATA_W-1:0] rf_din_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [ADDR_W-1:0] next_addr;
  logic              last_addr;

  assign next_addr = lat_addr + ADDR_W'(1);
  assign last_addr = &lat_addr;

  // ready is masked by reset so no command can slip in during a reset cycle
  assign bus.cmd_ready = ready_q && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rf_wr     = rf_wr_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_din    = rf_din_q;
  assign bus.rf_addr   = rf_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_write   <= 1'b0;
      lat_dump    <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
      rf_wr_q     <= 1'b0;
      rf_rd_q     <= 1'b0;
      rf_din_q    <= '0;
      rf_addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            lat_write <= bus.cmd_write && !bus.cmd_dump;
            lat_dump  <= bus.cmd_dump;
            lat_addr  <= bus.cmd_dump ? '0 : bus.cmd_addr;
            lat_wdata <= bus.cmd_wdata;
            rf_addr_q <= bus.cmd_dump ? '0 : bus.cmd_addr;
            rf_din_q  <= bus.cmd_wdata;
            rf_wr_q   <= bus.cmd_write && !bus.cmd_dump;
            rf_rd_q   <= !bus.cmd_write || bus.cmd_dump;
            ready_q   <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          rf_wr_q   <= 1'b0;
          rf_rd_q   <= 1'b0;
          rf_din_q  <= '0;
          rf_addr_q <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          rsp_rdata_q <= lat_write ? '0 : bus.rf_dout;
          rsp_error_q <= bus.rf_error;
          rsp_addr_q  <= lat_addr;
          rsp_last_q  <= !lat_dump || last_addr;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (lat_dump && !last_addr) begin
              // the next dump read is strobed directly from the handshake
              lat_addr  <= next_addr;
              rf_addr_q <= next_addr;
              rf_din_q  <= lat_wdata;
              rf_rd_q   <= 1'b1;
              state     <= ISSUE;
            end else begin
              ready_q <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_master.sv
// tb/tb_regfile_master.sv - Self-checking bench for regfile_master against a queue-based model
module tb_regfile_master;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NENT = 1 << AW;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic          err;
    logic          last;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_master #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cnt = 0;
  bit err_en = 1'b0;
  bit rand_ready = 1'b0;
  bit ready_level = 1'b1;

  logic [DW-1:0] rf_mem [NENT] = '{default: '0};
  logic [DW-1:0] ref_mem [NENT] = '{default: '0};

  rsp_t exp_q [$];
  rsp_t got_q [$];
  int   got_cyc [$];

  bit            exp_stb = 1'b0;
  bit            exp_stb_wr = 1'b0;
  logic [AW-1:0] exp_stb_addr = '0;
  logic [DW-1:0] exp_stb_din = '0;
  bit            exp_idle = 1'b0;
  bit            prev_valid = 1'b0;
  int            ref_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // register file stand-in: registered read data and error, one cycle after a strobe
  always @(posedge clk) begin
    if (bus.rf_wr) rf_mem[bus.rf_addr] <= bus.rf_din;
    if (bus.rf_rd) begin
      bus.rf_dout <= rf_mem[bus.rf_addr];
      rd_cnt <= rd_cnt + 1;
    end
    bus.rf_error <= (bus.rf_wr || bus.rf_rd) && err_en && (bus.rf_addr == AW'(6));
  end

  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // reference model and per-cycle comparison
  always @(negedge clk) begin
    rsp_t e;
    rsp_t a;
    if (reset) begin
      exp_q.delete();
      exp_stb = 1'b0;
      exp_idle = 1'b0;
      prev_valid = 1'b0;
    end else begin
      chk("strobe_exclusive", int'(bus.rf_wr && bus.rf_rd), 0);
      chk("ready_with_valid", int'(bus.cmd_ready && bus.rsp_valid), 0);
      chk("rf_wr", int'(bus.rf_wr), int'(exp_stb && exp_stb_wr));
      chk("rf_rd", int'(bus.rf_rd), int'(exp_stb && !exp_stb_wr));
      chk("rf_addr", int'(bus.rf_addr), exp_stb ? int'(exp_stb_addr) : 0);
      if (!exp_stb || exp_stb_wr) chk("rf_din", int'(bus.rf_din), exp_stb ? int'(exp_stb_din) : 0);
      if (exp_idle) chk("cmd_ready_after_last", int'(bus.cmd_ready), 1);
      exp_stb = 1'b0;
      exp_idle = 1'b0;
      if (bus.rsp_valid && !prev_valid) chk("rsp_latency", cyc - ref_cyc, 3);
      prev_valid = bus.rsp_valid;
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q[0];
          a = '{rdata: bus.rsp_rdata, addr: bus.rsp_addr, err: bus.rsp_error, last: bus.rsp_last};
          chk("rsp_rdata", int'(a.rdata), int'(e.rdata));
          chk("rsp_addr", int'(a.addr), int'(e.addr));
          chk("rsp_error", int'(a.err), int'(e.err));
          chk("rsp_last", int'(a.last), int'(e.last));
          if (bus.rsp_ready) begin
            void'(exp_q.pop_front());
            got_q.push_back(a);
            got_cyc.push_back(cyc);
            ref_cyc = cyc;
            if (e.last) begin
              exp_idle = 1'b1;
            end else begin
              exp_stb = 1'b1;
              exp_stb_wr = 1'b0;
              exp_stb_addr = AW'(e.addr + AW'(1));
            end
          end
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        ref_cyc = cyc;
        exp_stb = 1'b1;
        exp_stb_din = bus.cmd_wdata;
        if (bus.cmd_dump) begin
          exp_stb_wr = 1'b0;
          exp_stb_addr = '0;
          for (int k = 0; k < NENT; k++)
            exp_q.push_back('{rdata: ref_mem[k], addr: AW'(k), err: err_en && (k == 6), last: k == NENT - 1});
        end else if (bus.cmd_write) begin
          exp_stb_wr = 1'b1;
          exp_stb_addr = bus.cmd_addr;
          ref_mem[bus.cmd_addr] = bus.cmd_wdata;
          exp_q.push_back('{rdata: '0, addr: bus.cmd_addr, err: err_en && (bus.cmd_addr == AW'(6)), last: 1'b1});
        end else begin
          exp_stb_wr = 1'b0;
          exp_stb_addr = bus.cmd_addr;
          exp_q.push_back('{rdata: ref_mem[bus.cmd_addr], addr: bus.cmd_addr,
                            err: err_en && (bus.cmd_addr == AW'(6)), last: 1'b1});
        end
      end
    end
  end

  task automatic send_cmd(input bit w, input bit d, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_dump = d;
    bus.cmd_addr = a;
    bus.cmd_wdata = wd;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = AW'($urandom);
    bus.cmd_wdata = DW'($urandom);
    if (!ok) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("completion_timeout", 0, 1);
  endtask

  initial begin
    int base;
    int errs;
    int vcnt;
    logic [DW-1:0] held;
    bit found;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_dump = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", int'(bus.cmd_ready), 0);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_rsp_rdata", int'(bus.rsp_rdata), 0);
    chk("reset_rsp_last", int'(bus.rsp_last), 0);
    chk("reset_strobes", int'({bus.rf_wr, bus.rf_rd}), 0);
    reset = 1'b0;
    #1;
    chk("cmd_ready_after_reset", int'(bus.cmd_ready), 1);

    // unwritten read
    got_q.delete();
    base = rd_cnt;
    send_cmd(1'b0, 1'b0, 3'd2, 8'h00);
    wait_done();
    chk("unwritten_rsp_count", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      chk("unwritten_rdata", int'(got_q[0].rdata), 0);
      chk("unwritten_error", int'(got_q[0].err), 0);
    end
    chk("unwritten_rd_pulses", rd_cnt - base, 1);

    // write then read
    got_q.delete();
    send_cmd(1'b1, 1'b0, 3'd5, 8'hA7);
    wait_done();
    send_cmd(1'b0, 1'b0, 3'd5, 8'h00);
    wait_done();
    chk("wr_rd_rsp_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("write_rsp_rdata", int'(got_q[0].rdata), 0);
      chk("write_rsp_last", int'(got_q[0].last), 1);
      chk("read_rsp_rdata", int'(got_q[1].rdata), 'hA7);
      chk("read_rsp_addr", int'(got_q[1].addr), 5);
      chk("read_rsp_error", int'(got_q[1].err), 0);
    end

    // fill and dump
    for (int k = 0; k < NENT; k++) begin
      send_cmd(1'b1, 1'b0, AW'(k), DW'(8'h10 + k));
      wait_done();
    end
    got_q.delete();
    got_cyc.delete();
    send_cmd(1'b0, 1'b1, 3'd4, 8'h00);
    wait_done();
    chk("dump_rsp_count", got_q.size(), NENT);
    if (got_q.size() == NENT) begin
      for (int k = 0; k < NENT; k++) begin
        chk("dump_rdata", int'(got_q[k].rdata), 'h10 + k);
        chk("dump_addr", int'(got_q[k].addr), k);
        chk("dump_last", int'(got_q[k].last), int'(k == NENT - 1));
        if (k > 0) chk("dump_spacing", got_cyc[k] - got_cyc[k-1], 3);
      end
    end

    // error flag passthrough
    err_en = 1'b1;
    got_q.delete();
    send_cmd(1'b0, 1'b0, 3'd6, 8'h00);
    wait_done();
    send_cmd(1'b0, 1'b0, 3'd1, 8'h00);
    wait_done();
    err_en = 1'b0;
    if (got_q.size() == 2) begin
      chk("error_addr6", int'(got_q[0].err), 1);
      chk("error_addr1", int'(got_q[1].err), 0);
    end else chk("error_rsp_count", got_q.size(), 2);

    // backpressure
    ready_level = 1'b0;
    @(posedge clk);
    got_q.delete();
    base = rd_cnt;
    send_cmd(1'b0, 1'b0, 3'd4, 8'h00);
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_rsp_seen", int'(found), 1);
    held = bus.rsp_rdata;
    chk("bp_rdata", int'(held), 'h14);
    vcnt = 0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid && bus.rsp_rdata == held && !bus.cmd_ready && !bus.rf_wr && !bus.rf_rd) vcnt++;
    end
    chk("bp_stable_cycles", vcnt, 10);
    chk("bp_rd_pulses", rd_cnt - base, 1);
    ready_level = 1'b1;
    wait_done();
    chk("bp_rsp_count", got_q.size(), 1);

    // randomized command stream
    rand_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 150; i++) begin
      int r = $urandom_range(0, 7);
      send_cmd(1'($urandom_range(0, 1)), r == 0, AW'($urandom), DW'($urandom));
      wait_done();
    end
    rand_ready = 1'b0;
    errs = 0;
    foreach (got_q[i]) if (got_q[i].err) errs++;
    chk("random_error_flags", errs, 0);

    // reset in the RESP of dump address 3
    @(posedge clk);
    send_cmd(1'b0, 1'b1, 3'd0, 8'h00);
    found = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid && bus.rsp_addr == AW'(3)) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_dump_addr3_seen", int'(found), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_cmd_ready", int'(bus.cmd_ready), 0);
    chk("mid_reset_rsp", int'({bus.rsp_valid, bus.rsp_error, bus.rsp_last}), 0);
    chk("mid_reset_rsp_data", int'({bus.rsp_rdata, bus.rsp_addr}), 0);
    chk("mid_reset_rf", int'({bus.rf_wr, bus.rf_rd, bus.rf_din, bus.rf_addr}), 0);
    reset = 1'b0;
    #1;
    chk("mid_reset_ready_after", int'(bus.cmd_ready), 1);
    vcnt = 0;
    base = rd_cnt;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) vcnt++;
    end
    chk("mid_reset_no_rsp", vcnt, 0);
    chk("mid_reset_no_strobe", rd_cnt - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/regfile_master.md
REGFILE_MASTER -- requirements
Module: regfile_master

Interface
REQ-001 Parameter DATA_W, default 8, data width of the register file.
REQ-002 Parameter ADDR_W, default 3, address width; the register file has 2**ADDR_W entries.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  master accepts a command this cycle.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_dump  input  1  1 = read all entries 0..2**ADDR_W-1 in order; overrides cmd_write.
REQ-009 cmd_addr  input  ADDR_W  target address for a single read or write.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  consumer takes the response.
REQ-013 rsp_rdata  output  DATA_W  read data; 0 for writes.
REQ-014 rsp_addr  output  ADDR_W  address this response refers to.
REQ-015 rsp_error  output  1  register-file error flag sampled for this access.
REQ-016 rsp_last  output  1  final response of the command (always 1 for single accesses).
REQ-017 rf_din, rf_addr, rf_wr, rf_rd  output  DATA_W/ADDR_W/1/1  register-file write data, address, write strobe, read strobe.
REQ-018 rf_dout, rf_error  input  DATA_W/1  register-file registered outputs, valid one cycle after a strobe.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready, which latches cmd_write, cmd_dump, cmd_addr and cmd_wdata and moves to ISSUE.
REQ-021 For a dump, the latched address SHALL be forced to 0 and cmd_addr ignored.
REQ-022 In ISSUE, for exactly one cycle, the block SHALL drive rf_addr and rf_din from the latched values and assert rf_wr (write) or rf_rd (read/dump), then go to WAIT.
REQ-023 rf_wr and rf_rd SHALL never be high in the same cycle; both SHALL be 0 outside ISSUE, and rf_din and rf_addr SHALL be 0 outside ISSUE.
REQ-024 In WAIT, the block SHALL capture rf_dout into rsp_rdata (0 for a write) and rf_error into rsp_error at the end of the cycle, then go to RESP.
REQ-025 In RESP, rsp_valid SHALL be 1, and rsp_rdata, rsp_addr, rsp_error and rsp_last SHALL be held stable until rsp_valid && rsp_ready.
REQ-026 On the RESP handshake, a single access or a dump at the last address SHALL return to IDLE; otherwise a dump SHALL increment the address and return to ISSUE.
REQ-027 rsp_last SHALL be 1 for single accesses and for the dump response at address 2**ADDR_W-1, and 0 otherwise.
REQ-028 Latency SHALL be: command accepted at cycle N, strobe at N+1, rsp_valid at N+3; with rsp_ready held at 1, the next cmd_ready is at N+4.
REQ-029 A dump with rsp_ready held at 1 SHALL produce one response every 3 cycles, 8 responses for ADDR_W=3.
REQ-030 With rsp_ready=0 the block SHALL stall in RESP indefinitely with no further strobes.
REQ-031 rsp_valid SHALL be 0 in every state except RESP.

Reset
REQ-032 While reset=1 at a rising edge, the block SHALL enter IDLE, abort any dump, discard any pending response, and clear all latched command fields and the dump counter.
REQ-033 After that edge, rsp_valid, rsp_rdata, rsp_addr, rsp_error, rsp_last, rf_wr, rf_rd, rf_din and rf_addr SHALL all be 0.
REQ-034 cmd_ready SHALL be 0 in any cycle where reset=1 and SHALL be 1 in the first cycle after reset deasserts.
REQ-035 A reset in the ISSUE cycle SHALL NOT suppress the strobe already driven in that cycle, and the block SHALL issue no further strobes.

Verification
REQ-036 Write then read: write addr 5 data 0xA7, then read addr 5 -> write response rdata=0x00, error=0, last=1; read response rdata=0xA7, addr=5, error=0.
REQ-037 Unwritten read: after reset, read addr 2 -> rsp_rdata=0x00, rsp_error=0, with rf_rd high for exactly 1 cycle.
REQ-038 Dump: write addr k with 0x10+k for k=0..7, then dump with rsp_ready=1 -> 8 responses with rdata 0x10..0x17 and addr 0..7, rsp_last only on addr 7, 3 cycles apart.
REQ-039 Backpressure: read with rsp_ready=0 for 10 cycles -> rsp_valid and data stable for 10 cycles, cmd_ready=0, no rf_wr or rf_rd activity; one cycle after rsp_ready=1 -> IDLE.
REQ-040 Reset mid-dump: assert reset during the RESP of address 3 -> next cycle all outputs 0 and no further responses; cmd_ready=1 after reset deasserts.
REQ-041 Strobe check: random command stream with a register-file model -> rf_wr && rf_rd never observed and rsp_error always 0.
